pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit for the WISC pipelined core. It replaces the fixed load-use and branch stall logic and the separate forwarding unit with one block. A per-stage scoreboard tracks in-flight destinations, load and flag producers, and halt markers across TRACK slots after ID (slot 0 = EX, slot TRACK-1 = WB). From that scoreboard the block generates stall, flush, bubble, forwarding selects, memory-wait freezes, halt drain and a stall performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the WISC core: a scoreboard of in-flight instructions after ID
// drives load-use/flag stalls, EX operand forwarding, memory-wait freezes and halt drain.
module pipe_hazard_ctrl #(
    parameter int RA_W       = 4,
    parameter int TRACK      = 3,
    parameter int LOAD_AVAIL = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter int SELW       = $clog2(TRACK + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_reg_wr,
    input  logic            id_is_load,
    input  logic            id_sets_flags,
    input  logic            id_uses_flags,
    input  logic            id_halt,
    input  logic            br_taken,
    input  logic            imem_busy,
    input  logic            dmem_busy,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic            pipe_we,
    output logic [SELW-1:0] fwd_a,
    output logic [SELW-1:0] fwd_b,
    output logic            hlt,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [TRACK-1:0] sb_valid;
    logic [TRACK-1:0] sb_reg_wr;
    logic [TRACK-1:0] sb_is_load;
    logic [TRACK-2:0] sb_halt;
    logic [RA_W-1:0]  sb_rd [TRACK];
    logic [RA_W-1:0]  ex_rs;
    logic [RA_W-1:0]  ex_rt;
    logic             ex_rs_used;
    logic             ex_rt_used;
    logic             ex_sets_flags;

    logic data_haz;
    logic flag_haz;
    logic stall;
    logic freeze;
    logic load_id;

    function automatic logic reg_match(input logic v, input logic wr,
                                       input logic [RA_W-1:0] rd, input logic [RA_W-1:0] r);
        return v && wr && (rd == r) && !(ZERO_REG && (r == '0));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // A producer in slot k is usable by the ID instruction once k+1 reaches its availability slot
    always_comb begin
        data_haz = 1'b0;
        for (int k = 0; k < TRACK; k++) begin
            if ((k + 1) < (sb_is_load[k] ? LOAD_AVAIL : 1)) begin
                if (id_rs_used && reg_match(sb_valid[k], sb_reg_wr[k], sb_rd[k], id_rs))
                    data_haz = 1'b1;
                if (id_rt_used && reg_match(sb_valid[k], sb_reg_wr[k], sb_rd[k], id_rt))
                    data_haz = 1'b1;
            end
        end
        data_haz = data_haz && id_valid;
        flag_haz = id_valid && id_uses_flags && sb_valid[0] && ex_sets_flags;
        stall    = (data_haz || flag_haz) && (state == RUN);
    end

    // Descending scan so the youngest matching producer wins
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = TRACK - 1; k >= 1; k--) begin
            if (sb_valid[0] && ex_rs_used && reg_match(sb_valid[k], sb_reg_wr[k], sb_rd[k], ex_rs))
                fwd_a = SELW'(k);
            if (sb_valid[0] && ex_rt_used && reg_match(sb_valid[k], sb_reg_wr[k], sb_rd[k], ex_rt))
                fwd_b = SELW'(k);
        end
    end

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_we     = 1'b0;
        load_id     = 1'b0;
        state_nx    = state;
        freeze      = dmem_busy || (state == HALTED);

        if (!freeze) begin
            pipe_we = 1'b1;
            if (stall) begin
                idex_bubble = 1'b1;
            end else begin
                ifid_we    = 1'b1;
                load_id    = 1'b1;
                pc_we      = !((imem_busy && !br_taken) || (state == DRAIN));
                ifid_flush = br_taken || imem_busy || (state == DRAIN);
            end
        end

        case (state)
            RUN:     if (load_id && id_valid && id_halt) state_nx = DRAIN;
            DRAIN:   if (pipe_we && sb_valid[TRACK-2] && sb_halt[TRACK-2]) state_nx = HALTED;
            HALTED:  state_nx = HALTED;
            default: state_nx = RUN;
        endcase
    end

    assign hlt = (state == HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if ((stall || dmem_busy) && (state != HALTED))
            stall_cnt <= sat_inc(stall_cnt);
    end

    // Only the valid bits need reset; every other slot field is qualified by them
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_valid <= '0;
        else if (pipe_we)
            sb_valid <= {sb_valid[TRACK-2:0], load_id && id_valid};
    end

    always_ff @(posedge clk) begin
        if (pipe_we) begin
            sb_reg_wr  <= {sb_reg_wr[TRACK-2:0], id_reg_wr};
            sb_is_load <= {sb_is_load[TRACK-2:0], id_is_load};
            sb_halt[0] <= id_halt;
            for (int k = 1; k < TRACK - 1; k++)
                sb_halt[k] <= sb_halt[k-1];
            for (int k = 1; k < TRACK; k++)
                sb_rd[k] <= sb_rd[k-1];
            sb_rd[0]      <= id_rd;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rs_used    <= id_rs_used;
            ex_rt_used    <= id_rt_used;
            ex_sets_flags <= id_sets_flags;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two configurations (TRACK=3/LOAD_AVAIL=2 and
// TRACK=5/LOAD_AVAIL=3) share one stimulus stream and are checked against a queue-based model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       rsu;
        logic       rtu;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       sf;
        logic       uf;
        logic       hl;
        logic       br;
        logic       ib;
        logic       db;
    } stim_t;

    typedef struct packed {
        logic        pc_we;
        logic        ifid_we;
        logic        ifid_flush;
        logic        idex_bubble;
        logic        pipe_we;
        logic [2:0]  fwd_a;
        logic [2:0]  fwd_b;
        logic        hlt;
        logic [15:0] stall_cnt;
    } resp_t;

    typedef struct packed {
        logic       v;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       wr;
        logic       ld;
        logic       fl;
        logic       hl;
        logic       rsu;
        logic       rtu;
    } ent_t;

    logic clk = 1'b0;
    logic rst, id_valid, id_rs_used, id_rt_used, id_reg_wr, id_is_load;
    logic id_sets_flags, id_uses_flags, id_halt, br_taken, imem_busy, dmem_busy;
    logic [3:0] id_rs, id_rt, id_rd;

    logic pc_we0, ifid_we0, ifid_flush0, idex_bubble0, pipe_we0, hlt0;
    logic pc_we1, ifid_we1, ifid_flush1, idex_bubble1, pipe_we1, hlt1;
    logic [1:0] fa0, fb0;
    logic [2:0] fa1, fb1;
    logic [15:0] sc0, sc1;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    resp_t expq0[$];
    resp_t expq1[$];

    ent_t pipe[2][5];
    bit   draining[2];
    bit   halted[2];
    int   scnt[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_is_load(id_is_load), .id_sets_flags(id_sets_flags), .id_uses_flags(id_uses_flags),
        .id_halt(id_halt), .br_taken(br_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_we(pc_we0), .ifid_we(ifid_we0), .ifid_flush(ifid_flush0), .idex_bubble(idex_bubble0),
        .pipe_we(pipe_we0), .fwd_a(fa0), .fwd_b(fb0), .hlt(hlt0), .stall_cnt(sc0)
    );

    pipe_hazard_ctrl #(.RA_W(4), .TRACK(5), .LOAD_AVAIL(3), .ZERO_REG(1'b1), .SELW(3)) u_dut5 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_is_load(id_is_load), .id_sets_flags(id_sets_flags), .id_uses_flags(id_uses_flags),
        .id_halt(id_halt), .br_taken(br_taken), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_we(pc_we1), .ifid_we(ifid_we1), .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1),
        .pipe_we(pipe_we1), .fwd_a(fa1), .fwd_b(fb1), .hlt(hlt1), .stall_cnt(sc1)
    );

    // ---------------- reference model ----------------
    function automatic int tr(int d);
        return (d == 0) ? 3 : 5;
    endfunction

    function automatic int lavail(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic bit writes_reg(ent_t e, logic [3:0] r);
        return e.v && e.wr && (e.rd == r) && (r != 4'd0);
    endfunction

    function automatic bit model_stall(int d, stim_t s);
        bit haz;
        int lat;
        haz = 1'b0;
        for (int k = 0; k < tr(d); k++) begin
            lat = pipe[d][k].ld ? lavail(d) : 1;
            if (s.v && (k + 1 < lat) &&
                ((s.rsu && writes_reg(pipe[d][k], s.rs)) || (s.rtu && writes_reg(pipe[d][k], s.rt))))
                haz = 1'b1;
        end
        if (s.v && s.uf && pipe[d][0].v && pipe[d][0].fl)
            haz = 1'b1;
        return haz && !draining[d] && !halted[d];
    endfunction

    function automatic logic [2:0] fwd_of(int d, logic [3:0] r, bit used);
        for (int k = 1; k < tr(d); k++)
            if (used && writes_reg(pipe[d][k], r)) return 3'(k);
        return 3'd0;
    endfunction

    function automatic resp_t model_out(int d, stim_t s);
        resp_t o;
        bit st;
        o  = '0;
        st = model_stall(d, s);
        if (!(s.db || halted[d])) begin
            o.pipe_we = 1'b1;
            if (st) begin
                o.idex_bubble = 1'b1;
            end else begin
                o.ifid_we    = 1'b1;
                o.pc_we      = !(draining[d] || (s.ib && !s.br));
                o.ifid_flush = s.br || s.ib || draining[d];
            end
        end
        o.fwd_a     = fwd_of(d, pipe[d][0].rs, pipe[d][0].v && pipe[d][0].rsu);
        o.fwd_b     = fwd_of(d, pipe[d][0].rt, pipe[d][0].v && pipe[d][0].rtu);
        o.hlt       = halted[d];
        o.stall_cnt = 16'(scnt[d]);
        return o;
    endfunction

    task automatic model_clear(int d);
        for (int k = 0; k < 5; k++) pipe[d][k] = '0;
        draining[d] = 1'b0;
        halted[d]   = 1'b0;
        scnt[d]     = 0;
    endtask

    task automatic model_edge(int d, stim_t s);
        bit st, reach, start;
        ent_t e;
        if (s.rst) begin
            model_clear(d);
            return;
        end
        st = model_stall(d, s);
        if ((st || s.db) && !halted[d] && scnt[d] < 65535)
            scnt[d]++;
        if (!(s.db || halted[d])) begin
            reach = draining[d] && pipe[d][tr(d)-2].v && pipe[d][tr(d)-2].hl;
            start = !draining[d] && !st && s.v && s.hl;
            for (int k = tr(d) - 1; k >= 1; k--) pipe[d][k] = pipe[d][k-1];
            e = '0;
            if (!st && s.v) begin
                e.v = 1'b1; e.rd = s.rd; e.rs = s.rs; e.rt = s.rt; e.wr = s.wr; e.ld = s.ld;
                e.fl = s.sf; e.hl = s.hl; e.rsu = s.rsu; e.rtu = s.rtu;
            end
            pipe[d][0] = e;
            if (start) draining[d] = 1'b1;
            if (reach) halted[d] = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic apply(stim_t s);
        @(negedge clk);
        cyc++;
        rst = s.rst; id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_rs_used = s.rsu;
        id_rt_used = s.rtu; id_rd = s.rd; id_reg_wr = s.wr; id_is_load = s.ld;
        id_sets_flags = s.sf; id_uses_flags = s.uf; id_halt = s.hl; br_taken = s.br;
        imem_busy = s.ib; dmem_busy = s.db;
        for (int d = 0; d < 2; d++) begin
            if (s.rst) model_clear(d);
        end
        expq0.push_back(model_out(0, s));
        expq1.push_back(model_out(1, s));
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d, s);
    endtask

    function automatic stim_t ins(int rd, bit wr, int rs, int rt, bit ld, bit sf, bit uf, bit hl);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rd = 4'(rd); s.wr = wr; s.ld = ld; s.sf = sf; s.uf = uf; s.hl = hl;
        s.rsu = (rs >= 0); s.rs = (rs >= 0) ? 4'(rs) : 4'd0;
        s.rtu = (rt >= 0); s.rt = (rt >= 0) ? 4'(rt) : 4'd0;
        return s;
    endfunction

    task automatic nops(int n);
        for (int i = 0; i < n; i++) apply('0);
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(int d, string nm, logic [15:0] got, logic [15:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL dut%0d cycle %0d %s: got %0h expected %0h", d, cyc, nm, got, exp);
        end
    endtask

    task automatic check(int d, resp_t e, resp_t a);
        cmp(d, "pc_we", 16'(a.pc_we), 16'(e.pc_we));
        cmp(d, "ifid_we", 16'(a.ifid_we), 16'(e.ifid_we));
        cmp(d, "ifid_flush", 16'(a.ifid_flush), 16'(e.ifid_flush));
        cmp(d, "idex_bubble", 16'(a.idex_bubble), 16'(e.idex_bubble));
        cmp(d, "pipe_we", 16'(a.pipe_we), 16'(e.pipe_we));
        cmp(d, "fwd_a", 16'(a.fwd_a), 16'(e.fwd_a));
        cmp(d, "fwd_b", 16'(a.fwd_b), 16'(e.fwd_b));
        cmp(d, "hlt", 16'(a.hlt), 16'(e.hlt));
        cmp(d, "stall_cnt", a.stall_cnt, e.stall_cnt);
    endtask

    initial begin
        resp_t a;
        forever begin
            @(negedge clk);
            #2;
            if (expq0.size() > 0) begin
                a = '{pc_we0, ifid_we0, ifid_flush0, idex_bubble0, pipe_we0,
                      {1'b0, fa0}, {1'b0, fb0}, hlt0, sc0};
                check(0, expq0.pop_front(), a);
            end
            if (expq1.size() > 0) begin
                a = '{pc_we1, ifid_we1, ifid_flush1, idex_bubble1, pipe_we1, fa1, fb1, hlt1, sc1};
                check(1, expq1.pop_front(), a);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        stim_t s;
        rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_rd = 0; id_reg_wr = 0; id_is_load = 0; id_sets_flags = 0; id_uses_flags = 0;
        id_halt = 0; br_taken = 0; imem_busy = 0; dmem_busy = 0;
        for (int d = 0; d < 2; d++) model_clear(d);

        s = '0; s.rst = 1'b1;
        apply(s); apply(s);
        nops(1);

        // load-use: LW R3 then ADD R4,R3,R5 held in ID
        apply(ins(3, 1, 1, -1, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) apply(ins(4, 1, 3, 5, 0, 0, 0, 0));
        nops(4);

        // ALU forwarding, then the same with R0 as destination
        apply(ins(3, 1, 1, 2, 0, 0, 0, 0));
        apply(ins(6, 1, 5, 3, 0, 0, 0, 0));
        nops(3);
        apply(ins(0, 1, 1, 2, 0, 0, 0, 0));
        apply(ins(6, 1, 5, 0, 0, 0, 0, 0));
        nops(3);

        // flag hazard then taken branch
        apply(ins(6, 1, 1, 2, 0, 1, 0, 0));
        apply(ins(0, 0, -1, -1, 0, 0, 1, 0));
        s = ins(0, 0, -1, -1, 0, 0, 1, 0); s.br = 1'b1;
        apply(s);
        nops(2);

        // memory wait during a load-use stall
        apply(ins(3, 1, 1, -1, 1, 0, 0, 0));
        s = ins(4, 1, 3, 5, 0, 0, 0, 0); s.db = 1'b1;
        for (int i = 0; i < 3; i++) apply(s);
        for (int i = 0; i < 3; i++) apply(ins(4, 1, 3, 5, 0, 0, 0, 0));
        nops(3);

        // halt drain, then reset out of HALTED
        apply(ins(0, 0, -1, -1, 0, 0, 0, 1));
        nops(7);
        s = '0; s.rst = 1'b1;
        apply(s);
        nops(2);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst = ($urandom_range(59) == 0);
            s.v   = ($urandom_range(9) < 8);
            s.rs  = 4'($urandom_range(3));
            s.rt  = 4'($urandom_range(3));
            s.rsu = 1'($urandom_range(1));
            s.rtu = 1'($urandom_range(1));
            s.rd  = 4'($urandom_range(3));
            s.wr  = ($urandom_range(3) != 0);
            s.ld  = ($urandom_range(3) == 0);
            s.sf  = 1'($urandom_range(1));
            s.uf  = ($urandom_range(6) == 0);
            s.hl  = ($urandom_range(99) == 0);
            s.br  = ($urandom_range(9) == 0);
            s.ib  = ($urandom_range(9) == 0);
            s.db  = ($urandom_range(9) == 0);
            apply(s);
        end

        // stall counter saturation under a long memory wait
        s = '0; s.rst = 1'b1;
        apply(s);
        s = '0; s.db = 1'b1;
        for (int i = 0; i < 65540; i++) apply(s);
        nops(2);

        @(negedge clk);
        #5;
        ntests++;
        if (expq0.size() != 0 || expq1.size() != 0) begin
            nfail++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", expq0.size(), expq1.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
